ram_master: RTL and testbench
=============================

// Module: ram_master
// PURPOSE
//  CPU/bus-side initiator for ram_driver: accepts one memory request at a time, sequences
//  ram_driver's enable/enable_read/enable_write handshake, and returns read data or a write ack.
//  Partial-word stores (byte enables) are executed as read-modify-write. Sits between CPU mem stage and ram_driver.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles to wait for read_ready/write_finished before abort (RAM_MASTER_TIMEOUT_EN only)
// PORTS
//  clk                 in   1   sole clock, all logic on posedge
//  rst_n               in   1   synchronous reset, active-low
//  req_valid           in   1   request present
//  req_ready           out  1   request accepted when req_valid && req_ready
//  req_write           in   1   1 = store, 0 = load
//  req_addr            in   32  byte address; [22:2] used, others ignored
//  req_be              in   4   byte enables for stores ([0] = bits 7:0); ignored on loads
//  req_wdata           in   32  store data
//  resp_valid          out  1   one-cycle completion pulse
//  resp_rdata          out  32  load data, valid with resp_valid (0 for stores)
//  resp_err            out  1   timeout abort, valid with resp_valid
//  ram_enable          out  1   to ram_driver enable
//  ram_enable_read     out  1   to ram_driver enable_read
//  ram_enable_write    out  1   to ram_driver enable_write
//  ram_addr            out  21  word address to ram_driver, held stable for the whole transaction
//  ram_data_in         out  32  write data to ram_driver
//  ram_data_out        in   32  read data from ram_driver
//  ram_read_ready      in   1   ram_driver read data valid
//  ram_write_finished  in   1   ram_driver write done (one-cycle pulse)
// BEHAVIOUR
//  - Reset: all outputs 0 except req_ready=1; state IDLE; request latches cleared.
//  - req_ready=1 only in IDLE. On accept: latch addr[22:2], be, wdata, write.
//  - States: IDLE, RD, RD_REL, WR_ISSUE, WR_WAIT.
//  - Load or partial store (be != 4'hF and != 0): IDLE->RD; RD drives enable=1, enable_read=1 until
//    ram_read_ready sampled 1; capture ram_data_out; ->RD_REL (enable=1, enable_read=0, exactly one cycle
//    so ram_driver returns to its idle). Load: resp_valid pulses in the RD_REL cycle, then ->IDLE.
//  - Partial store: in RD_REL, merge lanes (be[i] ? wdata : rdata byte) -> ram_data_in; RD_REL->WR_ISSUE.
//  - Full store (be=4'hF): IDLE->WR_ISSUE directly, ram_data_in = wdata.
//  - WR_ISSUE: enable=1, enable_write=1 for exactly one cycle (never longer: ram_driver restarts a write if
//    enable_write is still high when it returns idle); ->WR_WAIT (enable=1, enable_write=0) until
//    ram_write_finished sampled 1; resp_valid pulses next cycle in IDLE, where a new request may be accepted.
//  - be=0 store: no RAM access; resp_valid the cycle after accept.
//  - ram_enable_read and ram_enable_write never both high. ram_addr constant from accept to completion.
//  - resp_rdata holds last load value until next load completes; 0 on store completions.
//  - Reset mid-transaction: enables drop the same cycle reset is sampled; any pending response is discarded.
// CONFIGURATION
//  RAM_MASTER_TIMEOUT_EN defined: a counter runs in RD and WR_WAIT; on reaching TIMEOUT_CYCLES, abort with
//    resp_valid=1, resp_err=1, resp_rdata=0; RD aborts via RD_REL (driver released), WR_WAIT aborts to IDLE.
//    Counter clears on each state entry.
//  Undefined: no counter, resp_err tied 0, master waits indefinitely.
// STRUCTURE
//  - ram_master_pkg: state encoding constants, RAM_AW=21, BE_FULL=4'hF.
//  - Sub-module ram_byte_merge: combinational 4-lane byte merge (old, new, be) -> merged word.
// TESTING
//  - Load addr 0x0000_0010 with RAM word 4 = 0xDEADBEEF -> ram_addr=4, enable_read held until read_ready;
//    resp_rdata=0xDEADBEEF, one resp_valid pulse; enable_read low for 1 cycle before next request.
//  - Store be=F, addr 0x0040_0000, data 0x12345678 -> one-cycle enable_write, ram_addr=0x100000 (extram);
//    resp_valid one cycle after write_finished.
//  - Store be=4'b0010, data 0x0000AB00 onto word 0x11223344 -> read then write 0x1122AB44.
//  - Store be=0 -> no enable asserted; resp_valid next cycle. Back-to-back load accepted in that cycle.
//  - rst_n low while in RD -> enables 0 next cycle, req_ready=1, no resp_valid.
//  - RAM_MASTER_TIMEOUT_EN, read_ready stuck 0 -> resp_err=1 after 64 cycles in RD, then IDLE.

Source files
------------

// File: rtl/ram_master_pkg.sv
// Shared state encoding and constants for the ram_master request sequencer.
package ram_master_pkg;

   localparam int         RAM_AW  = 21;
   localparam logic [3:0] BE_FULL = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_RD_REL   = 3'd2,
      ST_WR_ISSUE = 3'd3,
      ST_WR_WAIT  = 3'd4
   } state_t;

   // Loads and partial stores both start with a RAM read; full and empty stores do not.
   function automatic logic needs_read(input logic write, input logic [3:0] be);
      return !write || ((be != BE_FULL) && (be != 4'h0));
   endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Combinational 4-lane byte merge: lanes with be set take new_word, the rest keep old_word.
module ram_byte_merge (
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   input  logic [3:0]  be,
   output logic [31:0] merged_word
);

   always_comb begin
      merged_word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged_word[8*i +: 8] = new_word[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/ram_master.sv
// Single-outstanding-request initiator for ram_driver; partial stores run as read-modify-write.
// Optional RAM_MASTER_TIMEOUT_EN adds an abort counter for stalled reads and writes.
module ram_master
   import ram_master_pkg::*;
`ifdef RAM_MASTER_TIMEOUT_EN
   #(parameter int TIMEOUT_CYCLES = 64)
`endif
   (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [3:0]        req_be,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              ram_enable,
   output logic              ram_enable_read,
   output logic              ram_enable_write,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_data_in,
   input  logic [31:0]       ram_data_out,
   input  logic              ram_read_ready,
   input  logic              ram_write_finished
);

   state_t            state_q, state_d;
   logic [RAM_AW-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              write_q, write_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_zero_q, resp_zero_d;
   logic              abort_q, abort_d;

   logic              accept;
   logic              rd_abort;
   logic              wr_abort;
   logic [31:0]       merged_word;
   logic              unused_addr_bits;

   assign accept           = req_valid && (state_q == ST_IDLE);
   assign unused_addr_bits = ^{req_addr[31:23], req_addr[1:0]};

   ram_byte_merge u_merge (
      .old_word    (ram_data_out),
      .new_word    (wdata_q),
      .be          (be_q),
      .merged_word (merged_word)
   );

`ifdef RAM_MASTER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] timer_q, timer_d;
   logic          timer_hit;
   logic          resp_err_q, resp_err_d;

   assign timer_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));
   assign rd_abort  = (state_q == ST_RD) && !ram_read_ready && timer_hit;
   assign wr_abort  = (state_q == ST_WR_WAIT) && !ram_write_finished && timer_hit;

   // Timer measures residency in the current state, so any transition restarts it.
   always_comb begin
      timer_d = timer_q;
      if (state_d != state_q) begin
         timer_d = '0;
      end else if ((state_q == ST_RD) || (state_q == ST_WR_WAIT)) begin
         timer_d = timer_q + 1'b1;
      end
      resp_err_d = rd_abort || wr_abort;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_q    <= '0;
         resp_err_q <= 1'b0;
      end else begin
         timer_q    <= timer_d;
         resp_err_q <= resp_err_d;
      end
   end

   assign resp_err = resp_err_q;
`else
   assign rd_abort = 1'b0;
   assign wr_abort = 1'b0;
   assign resp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         be_q         <= '0;
         wdata_q      <= '0;
         write_q      <= 1'b0;
         wr_data_q    <= '0;
         load_data_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_zero_q  <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         write_q      <= write_d;
         wr_data_q    <= wr_data_d;
         load_data_q  <= load_data_d;
         resp_valid_q <= resp_valid_d;
         resp_zero_q  <= resp_zero_d;
         abort_q      <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (needs_read(req_write, req_be)) begin
                  state_d = ST_RD;
               end else if (req_be == BE_FULL) begin
                  state_d = ST_WR_ISSUE;
               end
            end
         end
         ST_RD: begin
            if (ram_read_ready || rd_abort) begin
               state_d = ST_RD_REL;
            end
         end
         ST_RD_REL:   state_d = (write_q && !abort_q) ? ST_WR_ISSUE : ST_IDLE;
         ST_WR_ISSUE: state_d = ST_WR_WAIT;
         ST_WR_WAIT: begin
            if (ram_write_finished || wr_abort) begin
               state_d = ST_IDLE;
            end
         end
         default:     state_d = ST_IDLE;
      endcase
   end

   // Response flags are registered so the pulse lands in RD_REL for loads and in IDLE for stores.
   always_comb begin
      addr_d       = addr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      write_d      = write_q;
      wr_data_d    = wr_data_q;
      load_data_d  = load_data_q;
      resp_valid_d = 1'b0;
      resp_zero_d  = 1'b0;
      abort_d      = abort_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d  = req_addr[22:2];
               be_d    = req_be;
               wdata_d = req_wdata;
               write_d = req_write;
               abort_d = 1'b0;
               if (req_write) begin
                  wr_data_d = req_wdata;
               end
               if (req_write && (req_be == 4'h0)) begin
                  resp_valid_d = 1'b1;
                  resp_zero_d  = 1'b1;
               end
            end
         end
         ST_RD: begin
            if (ram_read_ready) begin
               if (write_q) begin
                  wr_data_d = merged_word;
               end else begin
                  load_data_d  = ram_data_out;
                  resp_valid_d = 1'b1;
               end
            end else if (rd_abort) begin
               abort_d      = 1'b1;
               resp_valid_d = 1'b1;
               resp_zero_d  = 1'b1;
            end
         end
         ST_WR_WAIT: begin
            if (ram_write_finished || wr_abort) begin
               resp_valid_d = 1'b1;
               resp_zero_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      req_ready        = (state_q == ST_IDLE);
      ram_enable       = (state_q != ST_IDLE);
      ram_enable_read  = (state_q == ST_RD);
      ram_enable_write = (state_q == ST_WR_ISSUE);
   end

   assign ram_addr    = addr_q;
   assign ram_data_in = wr_data_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = (resp_valid_q && resp_zero_q) ? 32'h0 : load_data_q;

endmodule

// File: tb/tb_ram_master.sv
// Randomised scoreboard bench for ram_master with a behavioural ram_driver and reference memory.
// Define RAM_MASTER_TIMEOUT_EN for both bench and RTL to also exercise the read timeout abort.
module tb_ram_master;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef enum {K_NONE, K_LOAD, K_PSTORE, K_FSTORE, K_ZERO} kind_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        ram_enable;
   logic        ram_enable_read;
   logic        ram_enable_write;
   logic [20:0] ram_addr;
   logic [31:0] ram_data_in;
   logic [31:0] ram_data_out;
   logic        ram_read_ready;
   logic        ram_write_finished;

   int          checks   = 0;
   int          failures = 0;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [int];
   logic [31:0] ram_mem [int];
   logic [20:0] pool [16];

   kind_t       cur_kind  = K_NONE;
   logic [20:0] exp_addr  = '0;
   bit          mon_en    = 0;
   bit          hold_rd   = 0;
   bit          stall_rd  = 0;
   int          rd_cycles = 0;
   bit          resp_due  = 0;

   ram_master dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_write          (req_write),
      .req_addr           (req_addr),
      .req_be             (req_be),
      .req_wdata          (req_wdata),
      .resp_valid         (resp_valid),
      .resp_rdata         (resp_rdata),
      .resp_err           (resp_err),
      .ram_enable         (ram_enable),
      .ram_enable_read    (ram_enable_read),
      .ram_enable_write   (ram_enable_write),
      .ram_addr           (ram_addr),
      .ram_data_in        (ram_data_in),
      .ram_data_out       (ram_data_out),
      .ram_read_ready     (ram_read_ready),
      .ram_write_finished (ram_write_finished)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drives one request, waits for acceptance and records the expected response and RAM effect.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input bit expect_err);
      int          guard;
      int          w;
      exp_t        e;
      logic [31:0] word;
      @(negedge clk);
      #1;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_be    = be;
      req_wdata = wdata;
      guard     = 0;
      while (!req_ready && guard < 1000) begin
         @(negedge clk);
         #1;
         guard++;
      end
      if (!req_ready) begin
         checkOutput("req_accept_timeout", {31'h0, req_ready}, 32'h1);
         req_valid = 1'b0;
         return;
      end
      w        = int'(addr[22:2]);
      exp_addr = addr[22:2];
      e.err    = 1'b0;
      e.rdata  = 32'h0;
      if (!wr) begin
         cur_kind = K_LOAD;
         e.rdata  = ref_mem[w];
      end else begin
         if (be == 4'h0)      cur_kind = K_ZERO;
         else if (be == 4'hF) cur_kind = K_FSTORE;
         else                 cur_kind = K_PSTORE;
         word = ref_mem[w];
         for (int i = 0; i < 4; i++) begin
            if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
         end
         ref_mem[w] = word;
      end
      if (expect_err) begin
         e.rdata = 32'h0;
         e.err   = 1'b1;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic waitDrain(input int bound);
      int n;
      n = 0;
      while (n < bound && !(exp_q.size() == 0 && req_ready && !ram_enable)) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Monitor, protocol checker and behavioural ram_driver, all acting on the falling edge.
   initial begin
      bit          prev_rr;
      bit          prev_ew;
      bit          allowed;
      int          rd_wait;
      int          wr_wait;
      bit          wr_pending;
      logic [20:0] wr_addr;
      logic [31:0] wr_data;
      exp_t        e;
      prev_rr    = 0;
      prev_ew    = 0;
      rd_wait    = 0;
      wr_wait    = 0;
      wr_pending = 0;
      wr_addr    = '0;
      wr_data    = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (resp_valid || resp_due) begin
               checkOutput("resp_timing", {31'h0, resp_valid}, {31'h0, resp_due});
            end
            if (resp_valid) begin
               checkOutput("resp_expected", {31'h0, exp_q.size() != 0}, 32'h1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  checkOutput("resp_rdata", resp_rdata, e.rdata);
                  checkOutput("resp_err", {31'h0, resp_err}, {31'h0, e.err});
               end
            end
            if (ram_enable_read || ram_enable_write) begin
               checkOutput("rw_exclusive", {31'h0, ram_enable_read & ram_enable_write}, 32'h0);
               checkOutput("enable_qual", {31'h0, ram_enable}, 32'h1);
            end
            if (ram_enable_write) begin
               checkOutput("write_one_cycle", {31'h0, prev_ew}, 32'h0);
            end
            if (prev_rr) begin
               checkOutput("read_release", {30'h0, ram_enable, ram_enable_read}, 32'h2);
            end
            if (ram_enable) begin
               checkOutput("ram_addr", {11'h0, ram_addr}, {11'h0, exp_addr});
               if (ram_enable_read)       allowed = (cur_kind == K_LOAD) || (cur_kind == K_PSTORE);
               else if (ram_enable_write) allowed = (cur_kind == K_FSTORE) || (cur_kind == K_PSTORE);
               else                       allowed = (cur_kind != K_NONE) && (cur_kind != K_ZERO);
               checkOutput("access_kind", {31'h0, allowed}, 32'h1);
            end
         end
         prev_ew = ram_enable_write;
         if (!rst_n) begin
            ram_read_ready     = 1'b0;
            ram_write_finished = 1'b0;
            wr_pending         = 0;
            prev_rr            = 0;
            prev_ew            = 0;
         end else begin
            ram_write_finished = 1'b0;
            if (ram_enable_read) begin
               if (!ram_read_ready && !hold_rd && !stall_rd) begin
                  if (rd_wait == 0) begin
                     ram_read_ready = 1'b1;
                     ram_data_out   = ram_mem[int'(ram_addr)];
                  end else begin
                     rd_wait--;
                  end
               end
            end else begin
               ram_read_ready = 1'b0;
               rd_wait        = $urandom_range(0, 3);
               ram_data_out   = $urandom;
            end
            if (ram_enable_write) begin
               wr_addr    = ram_addr;
               wr_data    = ram_data_in;
               wr_wait    = $urandom_range(1, 4);
               wr_pending = 1;
            end else if (wr_pending) begin
               wr_wait--;
               if (wr_wait == 0) begin
                  ram_mem[int'(wr_addr)] = wr_data;
                  ram_write_finished     = 1'b1;
                  wr_pending             = 0;
               end
            end
            prev_rr = ram_read_ready && ram_enable_read;
         end
         #2;
         resp_due = 0;
         if (rst_n) begin
            if (req_valid && req_ready && req_write && (req_be == 4'h0)) resp_due = 1;
            if (ram_read_ready && ram_enable_read && cur_kind == K_LOAD) resp_due = 1;
            if (ram_write_finished) resp_due = 1;
            if (stall_rd && ram_enable_read) begin
               rd_cycles++;
               if (rd_cycles == 64) resp_due = 1;
            end
         end
      end
   end

   initial begin
      logic [31:0] rnd;
      logic [31:0] val;
      logic [20:0] w21;
      logic [3:0]  be;
      int          sel;
      int          guard;

      rst_n              = 1'b0;
      req_valid          = 1'b0;
      req_write          = 1'b0;
      req_addr           = '0;
      req_be             = '0;
      req_wdata          = '0;
      ram_data_out       = '0;
      ram_read_ready     = 1'b0;
      ram_write_finished = 1'b0;

      pool[0] = 21'd4;
      pool[1] = 21'h100000;
      pool[2] = 21'd8;
      for (int i = 3; i < 16; i++) begin
         rnd     = $urandom;
         pool[i] = rnd[20:0];
      end
      for (int i = 0; i < 16; i++) begin
         val                  = $urandom;
         ram_mem[int'(pool[i])] = val;
         ref_mem[int'(pool[i])] = val;
      end
      ram_mem[4] = 32'hDEADBEEF;
      ref_mem[4] = 32'hDEADBEEF;
      ram_mem[8] = 32'h11223344;
      ref_mem[8] = 32'h11223344;

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("[TB] checking reset state");
      checkOutput("rst_req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("rst_enable", {31'h0, ram_enable}, 32'h0);
      checkOutput("rst_enable_read", {31'h0, ram_enable_read}, 32'h0);
      checkOutput("rst_enable_write", {31'h0, ram_enable_write}, 32'h0);
      checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      checkOutput("rst_resp_err", {31'h0, resp_err}, 32'h0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
      checkOutput("rst_ram_addr", {11'h0, ram_addr}, 32'h0);
      checkOutput("rst_ram_data_in", ram_data_in, 32'h0);
      #1;
      rst_n  = 1'b1;
      mon_en = 1;

      $display("[TB] directed transactions");
      applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h0040_0000, 4'hF, 32'h1234_5678, 1'b0);
      applyStimulus(1'b0, 32'h0040_0000, 4'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0020, 4'b0010, 32'h0000_AB00, 1'b0);
      applyStimulus(1'b0, 32'h0000_0020, 4'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 1'b0);
      applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
      waitDrain(300);

      $display("[TB] reset during read");
      hold_rd = 1;
      applyStimulus(1'b0, 32'h0000_0020, 4'h0, 32'h0, 1'b0);
      guard = 0;
      @(negedge clk);
      while (!ram_enable_read && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("mid_rd_reached", {31'h0, ram_enable_read}, 32'h1);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("mid_rst_enable", {31'h0, ram_enable}, 32'h0);
      checkOutput("mid_rst_enable_read", {31'h0, ram_enable_read}, 32'h0);
      checkOutput("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
      checkOutput("mid_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
      #1;
      exp_q.delete();
      cur_kind = K_NONE;
      hold_rd  = 0;
      rst_n    = 1'b1;

      $display("[TB] random transactions");
      for (int n = 0; n < 150; n++) begin
         rnd = $urandom;
         w21 = pool[$urandom_range(0, 15)];
         sel = $urandom_range(0, 9);
         val = $urandom;
         if (sel <= 3) begin
            applyStimulus(1'b0, {rnd[31:23], w21, rnd[1:0]}, rnd[7:4], val, 1'b0);
         end else if (sel <= 5) begin
            applyStimulus(1'b1, {rnd[31:23], w21, rnd[1:0]}, 4'hF, val, 1'b0);
         end else if (sel <= 8) begin
            be = 4'($urandom_range(1, 14));
            applyStimulus(1'b1, {rnd[31:23], w21, rnd[1:0]}, be, val, 1'b0);
         end else begin
            applyStimulus(1'b1, {rnd[31:23], w21, rnd[1:0]}, 4'h0, val, 1'b0);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      waitDrain(300);

`ifdef RAM_MASTER_TIMEOUT_EN
      $display("[TB] read timeout abort");
      rd_cycles = 0;
      stall_rd  = 1;
      applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b1);
      waitDrain(300);
      stall_rd = 0;
      applyStimulus(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
      waitDrain(300);
`endif

      checkOutput("resp_outstanding", exp_q.size(), 32'h0);
      for (int i = 0; i < 16; i++) begin
         checkOutput("mem_word", ram_mem[int'(pool[i])], ref_mem[int'(pool[i])]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
